// File: rtl/lm75a_temp_bcd.sv
// Converts a signed LM75A reading to sign + three BCD integer digits + a BCD tenths digit,
// and keeps an over-temperature alarm with hysteresis.
// Latency: done is high 10 cycles after temp_valid is sampled; readings arriving while busy are dropped and flagged.
module lm75a_temp_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        temp_valid,
  input  logic [15:0] temp_raw,
  input  logic [7:0]  thresh_hi,
  input  logic [7:0]  thresh_lo,
  output logic        busy,
  output logic        done,
  output logic        neg,
  output logic [3:0]  bcd_hund,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic [3:0]  bcd_frac,
  output logic        alarm,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_CONVERT, S_UPDATE} state_t;

  state_t      state_q, state_d;
  logic [10:0] t_q, t_d;          // captured reading, 11-bit two's complement
  logic [19:0] dd_q, dd_d;        // double-dabble register {hund, tens, ones, binary}
  logic [2:0]  cnt_q, cnt_d;      // shift counter
  logic [3:0]  tenths_q, tenths_d;
  logic        sign_q, sign_d;
  logic        neg_q, neg_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d, frac_q, frac_d;
  logic        alarm_q, alarm_d;
  logic        overrun_q, overrun_d;

  logic [10:0]        mag;
  logic [3:0]         tenths_lut;
  logic [19:0]        dd_adj;
  logic [19:0]        dd_shift;
  logic signed [10:0] t_s;
  logic signed [10:0] ti_w;
  logic signed [7:0]  ti;
  logic               unused_bits;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Datapath helpers: magnitude, tenths lookup, floored integer for the alarm, one dabble step.
  always_comb begin
    mag = t_q[10] ? (~t_q + 11'd1) : t_q;
    case (mag[2:0])
      3'd0:    tenths_lut = 4'd0;
      3'd1:    tenths_lut = 4'd1;
      3'd2:    tenths_lut = 4'd2;
      3'd3:    tenths_lut = 4'd3;
      3'd4:    tenths_lut = 4'd5;
      3'd5:    tenths_lut = 4'd6;
      3'd6:    tenths_lut = 4'd7;
      default: tenths_lut = 4'd8;
    endcase
    t_s      = t_q;
    ti_w     = t_s >>> 3;
    ti       = ti_w[7:0];
    dd_adj   = {add3(dd_q[19:16]), add3(dd_q[15:12]), add3(dd_q[11:8]), dd_q[7:0]};
    dd_shift = {dd_adj[18:0], 1'b0};
  end

  assign unused_bits = ^{temp_raw[4:0], ti_w[10:8], dd_adj[19]};

  // Next-state and result computation; results and alarm land on the edge entering UPDATE.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    dd_d      = dd_q;
    cnt_d     = cnt_q;
    tenths_d  = tenths_q;
    sign_d    = sign_q;
    neg_d     = neg_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    frac_d    = frac_q;
    alarm_d   = alarm_q;
    overrun_d = temp_valid && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (temp_valid) begin
          t_d     = temp_raw[15:5];
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        sign_d   = t_q[10];
        dd_d     = {12'd0, mag[10:3]};
        tenths_d = tenths_lut;
        cnt_d    = 3'd0;
        state_d  = S_CONVERT;
      end
      S_CONVERT: begin
        dd_d  = dd_shift;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_UPDATE;
          neg_d   = sign_q;
          hund_d  = dd_shift[19:16];
          tens_d  = dd_shift[15:12];
          ones_d  = dd_shift[11:8];
          frac_d  = tenths_q;
          if (ti >= $signed(thresh_hi)) begin
            alarm_d = 1'b1;
          end else if (ti < $signed(thresh_lo)) begin
            alarm_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset clearing every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      dd_q      <= '0;
      cnt_q     <= '0;
      tenths_q  <= '0;
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      frac_q    <= '0;
      alarm_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      dd_q      <= dd_d;
      cnt_q     <= cnt_d;
      tenths_q  <= tenths_d;
      sign_q    <= sign_d;
      neg_q     <= neg_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      frac_q    <= frac_d;
      alarm_q   <= alarm_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_UPDATE);
  assign neg      = neg_q;
  assign bcd_hund = hund_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign bcd_frac = frac_q;
  assign alarm    = alarm_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_lm75a_temp_bcd.sv
// Bench for lm75a_temp_bcd: vector table plus overrun and mid-conversion reset sequences.
// Expected results are queued when a reading is driven and checked when done pulses.
module tb_lm75a_temp_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        temp_valid;
  logic [15:0] temp_raw;
  logic [7:0]  thresh_hi;
  logic [7:0]  thresh_lo;
  logic        busy, done, neg, alarm, overrun;
  logic [3:0]  bcd_hund, bcd_tens, bcd_ones, bcd_frac;

  lm75a_temp_bcd dut (
    .clk(clk), .reset(reset), .temp_valid(temp_valid), .temp_raw(temp_raw),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .busy(busy), .done(done),
    .neg(neg), .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bcd_frac(bcd_frac), .alarm(alarm), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        neg;
    logic [3:0]  h, t, o, f;
    logic        alarm;
  } vec_t;

  typedef struct {
    logic       neg;
    logic [3:0] h, t, o, f;
    logic       alarm;
    int         cyc;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard check on every done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("neg", int'(neg), int'(e.neg));
        chk("hund", int'(bcd_hund), int'(e.h));
        chk("tens", int'(bcd_tens), int'(e.t));
        chk("ones", int'(bcd_ones), int'(e.o));
        chk("frac", int'(bcd_frac), int'(e.f));
        chk("alarm", int'(alarm), int'(e.alarm));
      end
    end
  end

  task automatic push_exp(input vec_t v, input int at_cyc);
    exp_t x;
    x.neg = v.neg; x.h = v.h; x.t = v.t; x.o = v.o; x.f = v.f; x.alarm = v.alarm;
    x.cyc = at_cyc;
    sb.push_back(x);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_neg"}, int'(neg), 0);
    chk({nm, "_digits"}, int'({bcd_hund, bcd_tens, bcd_ones, bcd_frac}), 0);
    chk({nm, "_alarm"}, int'(alarm), 0);
    chk({nm, "_overrun"}, int'(overrun), 0);
  endtask

  // Called just after a negedge with the DUT idle; returns at the negedge of the cycle after done.
  task automatic send(input vec_t v);
    int n;
    temp_valid = 1'b1;
    temp_raw   = v.raw;
    thresh_hi  = v.hi;
    thresh_lo  = v.lo;
    push_exp(v, cyc + 10);
    @(negedge clk);
    temp_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done for raw %h", v.raw);
    end
    @(negedge clk);
  endtask

  vec_t v;

  initial begin
    vecs[0]  = '{16'h1900, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 1'b0};
    vecs[1]  = '{16'h7D00, 8'd127, 8'h80, 1'b0, 4'd1, 4'd2, 4'd5, 4'd0, 1'b0};
    vecs[2]  = '{16'hE700, 8'd127, 8'h80, 1'b1, 4'd0, 4'd2, 4'd5, 4'd0, 1'b0};
    vecs[3]  = '{16'hFFE0, 8'd127, 8'h80, 1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0};
    vecs[4]  = '{16'h1900, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 1'b0};
    vecs[5]  = '{16'h1920, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd1, 1'b0};
    vecs[6]  = '{16'h1940, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd2, 1'b0};
    vecs[7]  = '{16'h1960, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd3, 1'b0};
    vecs[8]  = '{16'h1980, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd5, 1'b0};
    vecs[9]  = '{16'h19A0, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd6, 1'b0};
    vecs[10] = '{16'h19C0, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd7, 1'b0};
    vecs[11] = '{16'h19E0, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd8, 1'b0};
    vecs[12] = '{16'h8000, 8'd127, 8'h80, 1'b1, 4'd1, 4'd2, 4'd8, 4'd0, 1'b0};
    vecs[13] = '{16'h0000, 8'd127, 8'h80, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[14] = '{16'h5100, 8'd80,  8'd75, 1'b0, 4'd0, 4'd8, 4'd1, 4'd0, 1'b1};
    vecs[15] = '{16'h4D00, 8'd80,  8'd75, 1'b0, 4'd0, 4'd7, 4'd7, 4'd0, 1'b1};
    vecs[16] = '{16'h4A00, 8'd80,  8'd75, 1'b0, 4'd0, 4'd7, 4'd4, 4'd0, 1'b0};
    vecs[17] = '{16'hFFE0, 8'hFF,  8'hFF, 1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 1'b1};
    vecs[18] = '{16'hFFE0, 8'd0,   8'd0,  1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0};
    vecs[19] = '{16'h1900, 8'd10,  8'd50, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 1'b1};

    // Reset with a simultaneous temp_valid: the reading must be ignored.
    reset = 1'b1; temp_valid = 1'b1; temp_raw = 16'h7D00;
    thresh_hi = 8'd127; thresh_lo = 8'h80;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0; temp_valid = 1'b0;
    @(negedge clk);
    chk("valid_during_reset_busy", int'(busy), 0);
    @(negedge clk);

    // Table: each reading issued in the cycle after the previous done.
    for (int i = 0; i < 20; i++) send(vecs[i]);

    // Overrun: second reading four cycles in is dropped; one done carries the first reading.
    begin
      int c0;
      c0 = cyc;
      chk("idle_busy", int'(busy), 0);
      v = '{16'h7D00, 8'd127, 8'h80, 1'b0, 4'd1, 4'd2, 4'd5, 4'd0, 1'b1};
      temp_valid = 1'b1; temp_raw = v.raw; thresh_hi = v.hi; thresh_lo = v.lo;
      push_exp(v, c0 + 10);
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        temp_valid = (k == 4);
        temp_raw   = (k == 4) ? 16'h1900 : 16'h7D00;
        chk($sformatf("busy_k%0d", k), int'(busy), (k <= 10) ? 1 : 0);
        chk($sformatf("overrun_k%0d", k), int'(overrun), (k == 5) ? 1 : 0);
      end
    end

    // Reset mid-conversion: no done, everything cleared, then a normal conversion.
    temp_valid = 1'b1; temp_raw = 16'h7D00; thresh_hi = 8'd127; thresh_lo = 8'h80;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      temp_valid = 1'b0;
      reset = (k == 5);
      if (k == 6) check_all_zero("midreset");
    end
    v = '{16'h1920, 8'd127, 8'h80, 1'b0, 4'd0, 4'd2, 4'd5, 4'd1, 1'b0};
    send(v);
    repeat (3) @(negedge clk);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_done: got %0d results outstanding expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lm75a_temp_bcd.md
LM75A_TEMP_BCD -- requirements
Module: lm75a_temp_bcd

Interface
REQ-001 SHALL: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL: temp_valid  input  1  one-cycle strobe marking temp_raw as a new LM75A reading.
REQ-004 SHALL: temp_raw  input  16  raw LM75A temperature word; bits[15:5] = 11-bit two's-complement value, LSB 0.125 degC; bits[4:0] ignored.
REQ-005 SHALL: thresh_hi  input  8  signed integer degC; alarm set threshold.
REQ-006 SHALL: thresh_lo  input  8  signed integer degC; alarm clear threshold (hysteresis).
REQ-007 SHALL: busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 SHALL: done  output  1  one-cycle pulse; result outputs updated in this cycle.
REQ-009 SHALL: neg  output  1  sign of the last converted reading (1 = negative).
REQ-010 SHALL: bcd_hund, bcd_tens, bcd_ones  output  4 each  BCD integer degrees of the magnitude.
REQ-011 SHALL: bcd_frac  output  4  BCD tenths digit of the magnitude.
REQ-012 SHALL: alarm  output  1  over-temperature flag with hysteresis.
REQ-013 SHALL: overrun  output  1  one-cycle pulse when temp_valid arrives while busy.

Function
REQ-014 SHALL: FSM states IDLE, ABS, CONVERT, UPDATE; IDLE->ABS on temp_valid; ABS->CONVERT; CONVERT->UPDATE after 8 shift cycles; UPDATE->IDLE.
REQ-015 SHALL: In IDLE with temp_valid=1, capture T = temp_raw[15:5] as 11-bit signed.
REQ-016 SHALL: ABS: M = |T| as 11-bit unsigned (T = -1024 gives M = 1024); I = M[10:3] (0..128); F = M[2:0]; sign = T[10].
REQ-017 SHALL: tenths = (F*10)>>3 truncated: F 0..7 -> 0,1,2,3,5,6,7,8.
REQ-018 SHALL: CONVERT: sequential double-dabble on I, one shift per cycle, exactly 8 cycles; add-3 on any BCD nibble >= 5 before each shift.
REQ-019 SHALL: Alarm integer Ti = T >>> 3 (arithmetic shift, floor); -0.125 gives Ti = -1.
REQ-020 SHALL: UPDATE: load neg, three BCD digits, bcd_frac; assert done for this single cycle.
REQ-021 SHALL: Alarm, evaluated in the UPDATE cycle only (signed compares): set if Ti >= thresh_hi; else clear if Ti < thresh_lo; else hold. Set wins if both conditions hold.
REQ-022 SHALL: Latency: temp_valid sampled on edge E0; done high in cycle E0+10; busy high in cycles E0+1 through E0+10 inclusive.
REQ-023 SHALL: Results and alarm hold their values between done pulses.
REQ-024 SHALL: temp_valid while busy (including the UPDATE cycle) is dropped; overrun pulses the following cycle; the conversion in progress is unaffected.
REQ-025 SHALL: Negative zero does not occur; T = 0 gives neg = 0.
REQ-026 SHALL: Back-to-back readings: temp_valid in the cycle after done is accepted.

Reset
REQ-027 SHALL: On reset, FSM = IDLE and all outputs = 0 (busy, done, neg, all BCD digits, alarm, overrun).
REQ-028 SHALL: Reset mid-conversion aborts it; no done pulse is produced and outputs go to 0.
REQ-029 SHALL: temp_valid in the same cycle as reset is ignored.

Verification
REQ-030 SHALL: temp_raw 0x1900 pulse -> after 10 cycles done=1, neg=0, digits 0,2,5, frac 0 (25.0).
REQ-031 SHALL: 0x7D00 -> 1,2,5 frac 0; 0xE700 -> neg=1, 0,2,5 frac 0; 0xFFE0 -> neg=1, 0,0,0 frac 1.
REQ-032 SHALL: 0x1920 -> 0,2,5 frac 1; sweep F = 0..7 and check frac = 0,1,2,3,5,6,7,8.
REQ-033 SHALL: thresh_hi=80, thresh_lo=75; feed 0x5100 (81.0) -> alarm 1; feed 0x4D00 (77.0) -> alarm 1; feed 0x4A00 (74.0) -> alarm 0.
REQ-034 SHALL: Second temp_valid at E0+4 -> overrun at E0+5, single done at E0+10 carrying the first reading.
REQ-035 SHALL: Reset at E0+5 -> no done, all outputs 0; a new reading after reset converts normally.
